signed_seq_divider_32: RTL and testbench
========================================

Name: signed_seq_divider_32

Overview:
- Multi-cycle signed integer divider; the inverse of the 32-bit signed array multiplier in the Week5 arithmetic set.
- Radix-2 restoring algorithm on magnitudes, with a sign fix-up at the end.
- Produces a truncated-toward-zero quotient and a remainder.
- Uses a start/busy/done handshake, so it can share a datapath with the multiplier in later ALU blocks.

Parameters:
- WIDTH, 32, operand width in bits (the quotient and remainder are also WIDTH bits).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request a division; sampled only in IDLE.
- dividend  in  WIDTH  two's-complement dividend; captured on the accepted start.
- divisor  in  WIDTH  two's-complement divisor; captured on the accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse; the results are valid from this cycle on.
- quotient  out  WIDTH  signed quotient; held until the next accepted start.
- remainder  out  WIDTH  signed remainder; sign follows the dividend.
- div_by_zero  out  1  set with done when divisor==0; held with the results.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, step counter=0.
- States and transitions:
  - IDLE -> LOAD on start=1.
  - LOAD -> RUN. Registers |dividend|, |divisor|, sign_q = dividend[MSB]^divisor[MSB], sign_r = dividend[MSB].
  - RUN: WIDTH iterations, one per clock. Each iteration shifts {rem,quo} left by 1, subtracts the divisor and restores if the result is negative. Counter runs 0..WIDTH-1.
  - RUN -> FIX after the last iteration. FIX applies the signs and writes the outputs.
  - FIX -> IDLE with done=1 for exactly one cycle.
- Latency: done is high during the cycle that begins WIDTH+2 rising edges after the edge that sampled start. For WIDTH=32 that is 34 edges.
- busy: 1 in LOAD, RUN and FIX; 0 in IDLE, including the done cycle.
- start while busy is ignored; no queuing. start held high continuously re-triggers in the cycle after done.
- Outputs change only in FIX, or on reset.
- Arithmetic:
  - Magnitudes are computed in WIDTH+1 bits, so |-2^(WIDTH-1)| is representable.
  - quotient = sign_q ? -q_mag : q_mag, truncated to WIDTH bits.
  - remainder = sign_r ? -r_mag : r_mag.
  - The invariant dividend == quotient*divisor + remainder holds mod 2^WIDTH.
- Overflow: 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000 (wraps), remainder=0, div_by_zero=0. No separate flag.
- Divide by zero: quotient=all ones, remainder=dividend (raw input value), div_by_zero=1. FIX overrides the sign logic in this case.
- Reset mid-operation aborts immediately; no done pulse follows.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: LOAD detects divisor==0 and goes straight to FIX. done arrives 3 edges after start; results as above.
- Undefined: a zero divisor runs the full WIDTH-iteration RUN. Latency is uniform at WIDTH+2 and the results are identical.
- Non-zero divisors are unaffected either way.

Decomposition:
- Shared package arith_pkg holds:
  - the state encoding constants (IDLE=0, LOAD=1, RUN=2, FIX=3);
  - WIDTH default 32;
  - the counter width localparam, clog2(WIDTH).
- One sub-module, div_restore_step. It is purely combinational. Inputs are the partial remainder, the quotient bits and the divisor magnitude; outputs are the next partial remainder and quotient bits.
- The top level owns the FSM, the counter, the sign handling and the output registers.

Test Plan:
- 0x0FFEF001 / 0x0000FFFF -> quotient=0x00000FFF, remainder=0. done exactly 34 edges after start; busy=1 for the preceding 33 cycles.
- 0xF0010FFF / 0x0000FFFF -> quotient=0xFFFFF001 (-4095), remainder=0. Also 0xF0010FFF / 0xFFFF0001 -> quotient=0x00000FFF.
- -7 / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). 7 / -2 -> quotient=-3, remainder=1.
- 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
- 0x12345678 / 0 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. done at edge 3 with DIV_ZERO_FAST_EN defined, edge 34 without.
- Start a division, then pulse rst at RUN iteration 10 -> all outputs 0 asynchronously, no done pulse. A new start after release gives correct results; a second start while busy is ignored.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: divider FSM encoding and sizing helpers.
package arith_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } div_state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step on magnitudes.
module div_restore_step
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH:0]   dmag,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;
  logic             diff_unused;

  assign sh          = {rem, quo[WIDTH-1]};
  assign diff        = {1'b0, sh} - {1'b0, dmag};
  assign diff_unused = diff[WIDTH];

  // partial remainder stays below the divisor, so WIDTH bits hold it
  always_comb begin
    rem_nxt = sh[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH+1]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/signed_seq_divider_32.sv
// Multi-cycle signed restoring divider with start/busy/done handshake.
// Optional DIV_ZERO_FAST_EN: zero divisor skips the iteration phase.
module signed_seq_divider_32
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_RUN = CW'(WIDTH - 2);

  div_state_t state, nstate;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_raw, b_raw;
  logic [WIDTH-1:0] rem, quo;
  logic [WIDTH:0]   dmag;
  logic             sign_q, sign_r, dz;

  logic [WIDTH-1:0] amag;
  logic [WIDTH:0]   bmag, bext;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             b_zero;

  assign amag   = a_raw[WIDTH-1] ? -a_raw : a_raw;
  assign bext   = {b_raw[WIDTH-1], b_raw};
  assign bmag   = b_raw[WIDTH-1] ? -bext : bext;
  assign b_zero = (b_raw == '0);
  assign busy   = (state != IDLE);

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem    (rem),
    .quo    (quo),
    .dmag   (dmag),
    .rem_nxt(rem_nxt),
    .quo_nxt(quo_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (start) nstate = LOAD;
`ifdef DIV_ZERO_FAST_EN
      LOAD: nstate = b_zero ? FIX : RUN;
`else
      LOAD: nstate = RUN;
`endif
      RUN:  if (cnt == LAST_RUN) nstate = FIX;
      FIX:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // final iteration is folded into FIX, feeding the sign fix-up directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      a_raw       <= '0;
      b_raw       <= '0;
      rem         <= '0;
      quo         <= '0;
      dmag        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_raw <= dividend;
            b_raw <= divisor;
          end
        end
        LOAD: begin
          quo    <= amag;
          rem    <= '0;
          dmag   <= bmag;
          sign_q <= a_raw[WIDTH-1] ^ b_raw[WIDTH-1];
          sign_r <= a_raw[WIDTH-1];
          dz     <= b_zero;
          cnt    <= '0;
        end
        RUN: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dz;
          if (dz) begin
            quotient  <= '1;
            remainder <= a_raw;
          end else begin
            quotient  <= sign_q ? -quo_nxt : quo_nxt;
            remainder <= sign_r ? -rem_nxt : rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_divider_32.sv
// Scoreboard bench for signed_seq_divider_32 (edge 1 = start-sampling edge).
module tb_signed_seq_divider_32;

`ifdef DIV_ZERO_FAST_EN
  localparam int LAT_Z = 3;
`else
  localparam int LAT_Z = 34;
`endif
  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  signed_seq_divider_32 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sd, q64, r64;
    if (b == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      sa   = longint'($signed(a));
      sd   = longint'($signed(b));
      q64  = sa / sd;
      r64  = sa % sd;
      e.q  = q64[31:0];
      e.r  = r64[31:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // drive one request and wait for done; returns edge count and busy cycles
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int edges, output int bcnt, output bit seen);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    edges = 1;
    bcnt  = 0;
    seen  = 0;
    @(negedge clk);
    start = 1'b0;
    while (!seen && edges < 200) begin
      if (done) seen = 1;
      else begin
        if (busy) bcnt++;
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got b%0b d%0b z%0b q=%h r=%h want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va[14];
    logic [31:0] vb[14];
    exp_t        e;
    int          edges, bcnt;
    bit          seen;
    logic [31:0] hq;
    va = '{32'h0FFE_F001, 32'hF001_0FFF, 32'hF001_0FFF, 32'hFFFF_FFF9,
           32'd7, 32'd100, 32'hFFFF_FF9C, 32'd0, 32'h7FFF_FFFF,
           32'h8000_0000, 32'd1, 32'h8000_0001, 32'd3, 32'hDEAD_BEEF};
    vb = '{32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_0001, 32'd2,
           32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFF9, 32'd5, 32'd1,
           32'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'd3, 32'h0000_1234};
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      if (i < 14) begin
        a = va[i];
        b = vb[i];
      end else begin
        a = $urandom;
        b = $urandom >> $urandom_range(0, 28);
        if (b == 0) b = 32'd9;
      end
      run_op(a, b, edges, bcnt, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen) begin
        n_bad++;
        $display("FAIL vec%0d_timeout no done within %0d edges", i, edges);
        continue;
      end
      n_cmp += 5;
      if (edges != LAT) begin
        n_bad++;
        $display("FAIL vec%0d_latency got %0d want %0d", i, edges, LAT);
      end
      if (bcnt != LAT - 1 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL vec%0d_busy got %0d cyc/%b want %0d/0",
                 i, bcnt, busy, LAT - 1);
      end
      if (quotient !== e.q) begin
        n_bad++;
        $display("FAIL vec%0d_quotient %h/%h got %h want %h",
                 i, a, b, quotient, e.q);
      end
      if (remainder !== e.r) begin
        n_bad++;
        $display("FAIL vec%0d_remainder %h/%h got %h want %h",
                 i, a, b, remainder, e.r);
      end
      if (div_by_zero !== 1'b0) begin
        n_bad++;
        $display("FAIL vec%0d_dz got %b want 0", i, div_by_zero);
      end
      hq = quotient;
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || quotient !== hq) begin
        n_bad++;
        $display("FAIL vec%0d_pulse done=%b q=%h want done=0 q=%h",
                 i, done, quotient, hq);
      end
    end
  endtask

  task automatic test_overflow();
    int edges, bcnt;
    bit seen;
    exp_t e;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, edges, bcnt, seen);
    e = sb.pop_front();
    n_cmp++;
    if (!seen || quotient !== 32'h8000_0000 || remainder !== 32'd0
        || div_by_zero !== 1'b0 || e.q !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL overflow got q=%h r=%h z=%b want 80000000/0/0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] za[2];
    int   edges, bcnt;
    bit   seen;
    exp_t e;
    za = '{32'h1234_5678, 32'hF000_0001};
    for (int i = 0; i < 2; i++) begin
      run_op(za[i], 32'd0, edges, bcnt, seen);
      e = sb.pop_front();
      n_cmp += 3;
      if (!seen || edges != LAT_Z || bcnt != LAT_Z - 1) begin
        n_bad++;
        $display("FAIL dz%0d_latency got %0d edges busy %0d want %0d",
                 i, edges, bcnt, LAT_Z);
      end
      if (quotient !== 32'hFFFF_FFFF || remainder !== za[i]) begin
        n_bad++;
        $display("FAIL dz%0d_result got q=%h r=%h want ffffffff/%h",
                 i, quotient, remainder, za[i]);
      end
      if (div_by_zero !== e.dz) begin
        n_bad++;
        $display("FAIL dz%0d_flag got %b want %b", i, div_by_zero, e.dz);
      end
    end
    run_op(32'd50, 32'd5, edges, bcnt, seen);
    e = sb.pop_front();
    n_cmp++;
    if (!seen || div_by_zero !== 1'b0 || quotient !== e.q) begin
      n_bad++;
      $display("FAIL dz_clear got z=%b q=%h want 0/%h",
               div_by_zero, quotient, e.q);
    end
  endtask

  task automatic test_reset_abort();
    int   edges, bcnt;
    bit   seen;
    exp_t e;
    run_op(32'd100, 32'd7, edges, bcnt, seen);
    e = sb.pop_front();
    n_cmp++;
    if (!seen || quotient !== e.q || remainder !== e.r) begin
      n_bad++;
      $display("FAIL abort_pre got q=%h r=%h want %h/%h",
               quotient, remainder, e.q, e.r);
    end
    @(negedge clk);
    dividend = 32'd999;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_bad++;
      $display("FAIL abort_async got b%0b d%0b q=%h r=%h want all 0",
               busy, done, quotient, remainder);
    end
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL abort_nodone got done pulse want none");
    end
    run_op(32'hFFFF_FC18, 32'd7, edges, bcnt, seen);
    e = sb.pop_front();
    n_cmp++;
    if (!seen || edges != LAT || quotient !== e.q || remainder !== e.r) begin
      n_bad++;
      $display("FAIL abort_after got q=%h r=%h e=%0d want %h/%h",
               quotient, remainder, edges, e.q, e.r);
    end
  endtask

  task automatic test_ignore_start();
    int   edges;
    bit   seen, extra;
    exp_t e;
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd9;
    start    = 1'b1;
    sb.push_back(model(32'd1000, 32'd9));
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
    dividend = 32'd77;
    divisor  = 32'd2;
    start    = 1'b1;
    @(posedge clk);
    edges++;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    while (!seen && edges < 200) begin
      if (done) seen = 1;
      else begin
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
    e = sb.pop_front();
    n_cmp += 2;
    if (!seen || edges != LAT) begin
      n_bad++;
      $display("FAIL ignore_latency got %0d want %0d", edges, LAT);
    end
    if (quotient !== e.q || remainder !== e.r) begin
      n_bad++;
      $display("FAIL ignore_result got %h/%h want %h/%h",
               quotient, remainder, e.q, e.r);
    end
    extra = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done || busy) extra = 1;
    end
    n_cmp++;
    if (extra) begin
      n_bad++;
      $display("FAIL ignore_noqueue got activity want idle");
    end
  endtask

  task automatic test_back_to_back();
    int   edges;
    bit   seen, held;
    exp_t e1, e2;
    @(negedge clk);
    dividend = 32'hFFFF_FFF9;
    divisor  = 32'd2;
    start    = 1'b1;
    sb.push_back(model(32'hFFFF_FFF9, 32'd2));
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    dividend = 32'd0;
    seen = 0;
    while (!seen && edges < 200) begin
      if (done) seen = 1;
      else begin
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
    e1 = sb.pop_front();
    n_cmp++;
    if (!seen || edges != LAT || quotient !== e1.q || remainder !== e1.r) begin
      n_bad++;
      $display("FAIL b2b_first got %h/%h e=%0d want %h/%h",
               quotient, remainder, edges, e1.q, e1.r);
    end
    dividend = 32'd7;
    divisor  = 32'hFFFF_FFFE;
    sb.push_back(model(32'd7, 32'hFFFF_FFFE));
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    held  = 1;
    while (!seen && edges < 200) begin
      if (done) seen = 1;
      else begin
        if (quotient !== e1.q || !busy) held = 0;
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
    e2 = sb.pop_front();
    n_cmp += 3;
    if (!held) begin
      n_bad++;
      $display("FAIL b2b_hold got q=%h busy=%b want %h/1",
               quotient, busy, e1.q);
    end
    if (!seen || edges != LAT) begin
      n_bad++;
      $display("FAIL b2b_latency got %0d want %0d", edges, LAT);
    end
    if (quotient !== e2.q || remainder !== e2.r) begin
      n_bad++;
      $display("FAIL b2b_second got %h/%h want %h/%h",
               quotient, remainder, e2.q, e2.r);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_vectors();
    test_overflow();
    test_div_zero();
    test_reset_abort();
    test_ignore_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
